// File: rtl/phy_tx_flit_queue.sv
// Transmit flit queue between router and phy: DEPTH-entry FIFO with flush and send gating.
// Optional PHY_TXQ_STATS_EN adds a 16-bit count of flits taken by the phy on sent_count.
module phy_tx_flit_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        flit_in,
    input  logic                     flit_valid,
    output logic                     flit_ready,
    input  logic                     enable_send,
    input  logic                     flush,
    output logic [DATA_W-1:0]        input_data_from_router,
    output logic                     phy_data_valid,
    input  logic                     phy_take,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              sent_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_wrPtr;
    logic [AW-1:0]       r_rdPtr;
    logic [CW-1:0]       r_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_push;
    logic                w_pop;

    // Readiness is judged on the current count only, so a full queue refuses even when a pop lands.
    assign flit_ready             = !rst && (r_count != FULL) && !flush;
    assign phy_data_valid         = (r_state == ST_HOLD) && enable_send;
    assign w_push                 = flit_valid && flit_ready;
    assign w_pop                  = phy_take && phy_data_valid;
    assign input_data_from_router = (r_state == ST_HOLD) ? r_mem[r_rdPtr] : '0;
    assign occupancy              = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case (r_state)
                ST_EMPTY: if (w_push) r_state <= ST_HOLD;
                ST_HOLD:  if (w_pop && !w_push && r_count == ONE) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    // Storage carries no reset; entries are only read while the FSM says they hold data.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= flit_in;
    end

`ifdef PHY_TXQ_STATS_EN
    logic [15:0] r_sentCount;

    // Flush does not clear the statistic, but a flush cycle is not a pop either.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sentCount <= '0;
        else if (w_pop && !flush)
            r_sentCount <= r_sentCount + 16'd1;
    end

    assign sent_count = r_sentCount;
`else
    assign sent_count = '0;
`endif

endmodule

// File: tb/tb_phy_tx_flit_queue.sv
// Self-checking bench for phy_tx_flit_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_phy_tx_flit_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic                   clk;
    logic                   rst;
    logic [DATA_W-1:0]      flit_in;
    logic                   flit_valid;
    logic                   flit_ready;
    logic                   enable_send;
    logic                   flush;
    logic [DATA_W-1:0]      input_data_from_router;
    logic                   phy_data_valid;
    logic                   phy_take;
    logic [$clog2(DEPTH):0] occupancy;
    logic [15:0]            sent_count;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [DATA_W-1:0] mq[$];
    int                sentModel = 0;

    phy_tx_flit_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .flit_in                (flit_in),
        .flit_valid             (flit_valid),
        .flit_ready             (flit_ready),
        .enable_send            (enable_send),
        .flush                  (flush),
        .input_data_from_router (input_data_from_router),
        .phy_data_valid         (phy_data_valid),
        .phy_take               (phy_take),
        .occupancy              (occupancy),
        .sent_count             (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue updated from the rules, sampled inputs are stable at each edge.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                sentModel = 0;
            end else if (flush) begin
                mq.delete();
            end else begin
                bit doPop;
                bit doPush;
                doPop  = phy_take && enable_send && (mq.size() > 0);
                doPush = flit_valid && (mq.size() < DEPTH);
                if (doPop) begin
                    void'(mq.pop_front());
                    sentModel = (sentModel + 1) % 65536;
                end
                if (doPush)
                    mq.push_back(flit_in);
            end
        end
    end

    task automatic compareOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] expData;
        logic [31:0] expSent;
        expData = (mq.size() > 0) ? mq[0] : 32'd0;
`ifdef PHY_TXQ_STATS_EN
        expSent = 32'(sentModel);
`else
        expSent = 32'd0;
`endif
        compareOne("flit_ready", 32'(flit_ready),
                   32'(!rst && (mq.size() < DEPTH) && !flush));
        compareOne("phy_data_valid", 32'(phy_data_valid), 32'((mq.size() > 0) && enable_send));
        compareOne("head_data", input_data_from_router, expData);
        compareOne("occupancy", 32'(occupancy), 32'(mq.size()));
        compareOne("sent_count", 32'(sent_count), expSent);
    endtask

    // Per-cycle compare against the model, half a cycle away from the sampling edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic take,
                                 input logic en, input logic fl);
        flit_valid  = v;
        flit_in     = d;
        phy_take    = take;
        enable_send = en;
        flush       = fl;
        @(posedge clk);
        #1;
        flit_valid = 1'b0;
        phy_take   = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        flit_in     = '0;
        flit_valid  = 1'b0;
        enable_send = 1'b1;
        flush       = 1'b0;
        phy_take    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compareOne("rst_ready", 32'(flit_ready), 32'd0);
        compareOne("rst_valid", 32'(phy_data_valid), 32'd0);
        compareOne("rst_occ", 32'(occupancy), 32'd0);
        compareOne("rst_data", input_data_from_router, 32'd0);
        rst = 1'b0;
        #1;
        compareOne("post_rst_ready", 32'(flit_ready), 32'd1);

        // Latency: a flit pushed into an empty queue is offered one cycle later.
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b1, 1'b0);
        compareOne("lat_valid", 32'(phy_data_valid), 32'd1);
        compareOne("lat_data", input_data_from_router, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        compareOne("lat_empty_data", input_data_from_router, 32'd0);

        // Full: fifth push refused, then drain in order.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 32'h10 + 32'(i), 1'b0, 1'b1, 1'b0);
        compareOne("full_ready", 32'(flit_ready), 32'd0);
        compareOne("full_occ", 32'(occupancy), 32'd4);
        for (int i = 0; i < 4; i++) begin
            compareOne("full_drain", input_data_from_router, 32'h10 + 32'(i));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        compareOne("drained_occ", 32'(occupancy), 32'd0);

        // Gating: take is ignored while enable_send is low.
        applyStimulus(1'b1, 32'h21, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        compareOne("gate_valid", 32'(phy_data_valid), 32'd0);
        compareOne("gate_occ", 32'(occupancy), 32'd2);
        compareOne("gate_head", input_data_from_router, 32'h21);

        // Concurrency: push and take together keep the count and the order.
        applyStimulus(1'b1, 32'hAA, 1'b1, 1'b1, 1'b0);
        compareOne("conc_occ", 32'(occupancy), 32'd2);
        compareOne("conc_head", input_data_from_router, 32'h22);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        compareOne("conc_last", input_data_from_router, 32'hAA);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Flush wins over a same-cycle push.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h31 + 32'(i), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h34, 1'b0, 1'b1, 1'b1);
        compareOne("flush_occ", 32'(occupancy), 32'd0);
        compareOne("flush_valid", 32'(phy_data_valid), 32'd0);

        // Asynchronous reset in the middle of a cycle clears outputs immediately.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h41 + 32'(i), 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        compareOne("arst_valid", 32'(phy_data_valid), 32'd0);
        compareOne("arst_data", input_data_from_router, 32'd0);
        compareOne("arst_occ", 32'(occupancy), 32'd0);
        compareOne("arst_ready", 32'(flit_ready), 32'd0);
        compareOne("arst_sent", 32'(sent_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 32'h51, 1'b0, 1'b1, 1'b0);
        compareOne("arst_first", input_data_from_router, 32'h51);

        // Randomized traffic, including occasional flush and reset pulses.
        for (int n = 0; n < 3000; n++) begin
            logic v, tk, en, fl;
            v  = ($urandom_range(0, 3) != 0);
            tk = ($urandom_range(0, 2) != 0);
            en = ($urandom_range(0, 4) != 0);
            fl = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0)
                rst = 1'b1;
            applyStimulus(v, $urandom, tk, en, fl);
            rst = 1'b0;
        end

`ifdef PHY_TXQ_STATS_EN
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++)
            applyStimulus(1'b1, 32'(i), 1'b1, 1'b1, 1'b0);
        compareOne("stats_70000", 32'(sent_count), 32'd4464);
`else
        applyStimulus(1'b1, 32'h61, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        compareOne("stats_tied", 32'(sent_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/phy_tx_flit_queue.md
PHY_TX_FLIT_QUEUE -- requirements
Module: phy_tx_flit_queue

Interface
REQ-001 SHALL have parameter: DATA_W, 32, flit width; must equal the phy input_data_from_router width.
REQ-002 SHALL have parameter: DEPTH, 4, queue entries; power of two, 2..16.
REQ-003 SHALL have port: clk  input  1  single clock for all state.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: flit_in  input  DATA_W  router flit.
REQ-006 SHALL have port: flit_valid  input  1  router offers flit_in.
REQ-007 SHALL have port: flit_ready  output  1  queue can accept.
REQ-008 SHALL have port: enable_send  input  1  gate for presenting flits to the phy.
REQ-009 SHALL have port: flush  input  1  synchronous discard of all entries.
REQ-010 SHALL have port: input_data_from_router  output  DATA_W  head flit to the phy.
REQ-011 SHALL have port: phy_data_valid  output  1  head flit is valid and offered.
REQ-012 SHALL have port: phy_take  input  1  single-cycle pulse; the phy has latched the head flit.
REQ-013 SHALL have port: occupancy  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 SHALL have port: sent_count  output  16  flits taken by the phy (see Configuration).

Function
REQ-015 SHALL accept a flit on a clk rising edge when flit_valid=1 and flit_ready=1.
REQ-016 SHALL drive flit_ready = (occupancy < DEPTH) and not flush; a push on a full cycle SHALL be refused even if phy_take pops in that cycle.
REQ-017 SHALL run a 2-state FSM: EMPTY (occupancy 0) and HOLD (occupancy >= 1); EMPTY->HOLD on push; HOLD->EMPTY on a pop of the last entry with no same-cycle push, or on flush.
REQ-018 SHALL drive phy_data_valid = (state==HOLD) and enable_send.
REQ-019 SHALL drive input_data_from_router from the head entry; value SHALL stay stable while phy_data_valid=1 and no pop has occurred.
REQ-020 SHALL make a flit pushed into an empty queue visible on input_data_from_router/phy_data_valid exactly 1 cycle after the push edge; there SHALL be no combinational path from flit_in.
REQ-021 SHALL pop the head on a cycle with phy_take=1 and phy_data_valid=1; next entry visible the following cycle.
REQ-022 SHALL ignore phy_take when phy_data_valid=0 (empty or enable_send=0); no pointer or count change.
REQ-023 SHALL, on simultaneous push and pop with 0 < occupancy < DEPTH, leave occupancy unchanged and keep FIFO order.
REQ-024 SHALL wrap read/write pointers modulo DEPTH without gaps or duplicates.
REQ-025 SHALL give flush priority over push and pop in the same cycle: occupancy -> 0, state -> EMPTY, the same-cycle push is dropped.
REQ-026 SHALL keep entry contents undefined-but-unobservable when empty; input_data_from_router SHALL read 0 when state==EMPTY.

Reset
REQ-027 SHALL, on rst=1 (asynchronous), force state EMPTY, pointers 0, occupancy 0, phy_data_valid 0, input_data_from_router 0, sent_count 0; flit_ready SHALL be 0 while rst=1.
REQ-028 SHALL, on rst asserted mid-transfer, discard all entries; the first flit after deassertion SHALL be the first pushed after deassertion.

Configuration
REQ-029 SHALL, with macro PHY_TXQ_STATS_EN defined, increment sent_count by 1 per pop (REQ-021), wrapping 0xFFFF->0x0000, cleared by rst only (not by flush).
REQ-030 SHALL, without PHY_TXQ_STATS_EN, tie sent_count to 0 and contain no counter logic.

Verification
REQ-031 SHALL test latency: push 0x00000001 into empty queue, enable_send=1 -> next cycle phy_data_valid=1, input_data_from_router=0x00000001.
REQ-032 SHALL test full: push 0x10..0x14 back-to-back without phy_take, DEPTH=4 -> 0x14 refused, flit_ready=0, occupancy=4; then 4 takes yield 0x10,0x11,0x12,0x13 in order.
REQ-033 SHALL test gating: occupancy=2, enable_send=0, pulse phy_take -> phy_data_valid=0, occupancy stays 2, head unchanged.
REQ-034 SHALL test concurrency: occupancy=2, push 0xAA and take same cycle -> occupancy=2, order preserved, 0xAA emerges last.
REQ-035 SHALL test flush/reset: occupancy=3, flush with flit_valid=1 -> occupancy=0, phy_data_valid=0; repeat with async rst mid-cycle -> all outputs 0 immediately.
REQ-036 SHALL test stats: with PHY_TXQ_STATS_EN, 70000 takes -> sent_count=4464; without the macro -> sent_count=0.
